// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one-request-deep IMEM fetcher feeding a single IF/ID slot,
// with a one-entry skid buffer, flush/redirect draining and fetch-exception capture.
`timescale 1ns/1ps

module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic [63:0] pc_if,
  output logic [63:0] npc_if,
  output logic [31:0] inst_if,
  output logic        valid_if,
  output logic        except_happen_if,
  output logic [3:0]  ecause_if,
  output logic        if_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BUF   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EXC   = 3'd4
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  cause;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{pc: 64'h0, inst: 32'h0, exc: 1'b0, cause: 4'h0};

  function automatic logic [63:0] pc_inc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  function automatic entry_t mk_entry(input logic [63:0] pc, input logic [31:0] inst,
                                      input logic exc, input logic [3:0] cause);
    entry_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.exc   = exc;
    e.cause = cause;
    return e;
  endfunction

  state_t      r_state;
  logic [63:0] r_fetch_pc;
  logic        r_slot_full;
  entry_t      r_slot;
  entry_t      r_buf;
  logic        r_imem_req;
  logic [63:0] r_imem_addr;
  logic [63:0] r_npc;
  logic        r_valid;
  logic        r_busy;

  state_t      w_state;
  logic [63:0] w_fetch_pc;
  logic        w_slot_full;
  entry_t      w_slot;
  entry_t      w_buf;
  logic        w_imem_req;
  logic [63:0] w_imem_addr;
  logic        w_consume;
  logic        w_slot_free;
  logic        w_pending;
  entry_t      w_resp;

  assign w_consume   = r_slot_full & ~stall & ~flush;
  assign w_slot_free = ~r_slot_full | w_consume;
  // A request is still in flight at this edge unless its response arrives now
  assign w_pending   = r_imem_req & ~imem_ready;
  assign w_resp      = mk_entry(r_fetch_pc, imem_fault ? 32'h0 : imem_rdata, imem_fault,
                                imem_fault ? 4'd1 : 4'd0);

  // Next-state, slot/buffer and request-output computation
  always_comb begin
    w_state     = r_state;
    w_fetch_pc  = r_fetch_pc;
    w_slot_full = r_slot_full;
    w_slot      = r_slot;
    w_buf       = r_buf;
    w_imem_req  = 1'b0;
    w_imem_addr = 64'h0;

    if (w_consume) begin
      w_slot_full = 1'b0;
      w_slot      = ENTRY_EMPTY;
    end else begin
      w_slot_full = r_slot_full;
    end

    case (r_state)
      ST_IDLE: begin
        w_state    = ST_REQ;
        w_fetch_pc = RESET_PC;
      end
      ST_REQ: begin
        if (r_fetch_pc[1:0] != 2'b00) begin
          if (w_slot_free) begin
            w_slot_full = 1'b1;
            w_slot      = mk_entry(r_fetch_pc, 32'h0, 1'b1, 4'd0);
            w_state     = ST_EXC;
          end else begin
            w_state = ST_REQ;
          end
        end else if (imem_ready) begin
          w_fetch_pc = pc_inc(r_fetch_pc);
          if (w_slot_free) begin
            w_slot_full = 1'b1;
            w_slot      = w_resp;
            w_state     = imem_fault ? ST_EXC : ST_REQ;
          end else begin
            w_buf   = w_resp;
            w_state = ST_BUF;
          end
        end else begin
          w_state = ST_REQ;
        end
      end
      ST_BUF: begin
        if (w_consume) begin
          w_slot_full = 1'b1;
          w_slot      = r_buf;
          w_buf       = ENTRY_EMPTY;
          w_state     = r_buf.exc ? ST_EXC : ST_REQ;
        end else begin
          w_state = ST_BUF;
        end
      end
      ST_DRAIN: begin
        if (imem_ready) begin
          w_state = ST_REQ;
        end else begin
          w_state = ST_DRAIN;
        end
      end
      ST_EXC: begin
        w_state = ST_EXC;
      end
      default: begin
        w_state    = ST_IDLE;
        w_fetch_pc = RESET_PC;
      end
    endcase

    if (flush) begin
      w_slot_full = 1'b0;
      w_slot      = ENTRY_EMPTY;
      w_buf       = ENTRY_EMPTY;
      w_fetch_pc  = redirect_pc;
      w_state     = w_pending ? ST_DRAIN : ST_REQ;
    end else begin
      w_fetch_pc = w_fetch_pc;
    end

    // DRAIN keeps presenting the abandoned request until memory answers it
    if (w_state == ST_DRAIN) begin
      w_imem_req  = 1'b1;
      w_imem_addr = r_imem_addr;
    end else if (w_state == ST_REQ && w_fetch_pc[1:0] == 2'b00) begin
      w_imem_req  = 1'b1;
      w_imem_addr = w_fetch_pc;
    end else begin
      w_imem_req  = 1'b0;
      w_imem_addr = 64'h0;
    end
  end

  // State, fetch PC, slot and skid-buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_slot_full <= 1'b0;
      r_slot      <= ENTRY_EMPTY;
      r_buf       <= ENTRY_EMPTY;
    end else begin
      r_state     <= w_state;
      r_fetch_pc  <= w_fetch_pc;
      r_slot_full <= w_slot_full;
      r_slot      <= w_slot;
      r_buf       <= w_buf;
    end
  end

  // Registered request and slot-status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_imem_req  <= 1'b0;
      r_imem_addr <= 64'h0;
      r_npc       <= 64'h0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_imem_req  <= w_imem_req;
      r_imem_addr <= w_imem_addr;
      r_npc       <= w_slot_full ? pc_inc(w_slot.pc) : 64'h0;
      r_valid     <= w_slot_full & ~w_slot.exc;
      r_busy      <= ~w_slot_full & (w_state != ST_EXC);
    end
  end

  assign imem_req         = r_imem_req;
  assign imem_addr        = r_imem_addr;
  assign pc_if            = r_slot.pc;
  assign npc_if           = r_npc;
  assign inst_if          = r_slot.inst;
  assign valid_if         = r_valid;
  assign except_happen_if = r_slot.exc;
  assign ecause_if        = r_slot.cause;
  assign if_busy          = r_busy;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle table for the stall/skid path,
// scoreboard of expected slot contents popped on every slot consumption.
`timescale 1ns/1ps

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_fault = 1'b0;
  logic [63:0] pc_if, npc_if;
  logic [31:0] inst_if;
  logic        valid_if, except_happen_if, if_busy;
  logic [3:0]  ecause_if;

  if_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_fault(imem_fault),
    .pc_if(pc_if), .npc_if(npc_if), .inst_if(inst_if), .valid_if(valid_if),
    .except_happen_if(except_happen_if), .ecause_if(ecause_if), .if_busy(if_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic force_ready = 1'b0;
  logic [63:0] fault_addr = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] memf(input logic [63:0] a);
    return 32'h0000_0013 ^ {a[21:2], 12'h000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] inst, input logic exc,
                      input logic [3:0] cause);
    exp_t e;
    e.pc = pc; e.inst = inst; e.exc = exc; e.cause = cause;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; force_ready = 1'b0;
    fault_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_sb(input string name, input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Memory model: answers the presented request after 'lat' wait cycles
  always @(negedge clk) begin
    if (imem_ready) wait_cnt = 0;
    if (!rst) wait_cnt = 0;
    if (force_ready) begin
      imem_ready = 1'b1; imem_rdata = memf(imem_addr); imem_fault = 1'b0;
    end else if (imem_req && wait_cnt >= lat) begin
      imem_ready = 1'b1; imem_rdata = memf(imem_addr); imem_fault = (imem_addr == fault_addr);
    end else begin
      imem_ready = 1'b0; imem_fault = 1'b0;
      if (imem_req) wait_cnt++;
    end
  end

  // Scoreboard: compare the slot each time it is about to be consumed
  always @(negedge clk) begin
    if (rst && !stall && !flush && (valid_if || except_happen_if) && sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      chk("sb_pc", pc_if, sb_e.pc);
      chk("sb_npc", npc_if, sb_e.pc + 64'd4);
      chk("sb_inst", 64'(inst_if), 64'(sb_e.inst));
      chk("sb_valid", 64'(valid_if), 64'(!sb_e.exc));
      chk("sb_exc", 64'(except_happen_if), 64'(sb_e.exc));
      chk("sb_cause", 64'(ecause_if), 64'(sb_e.cause));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_req;
    tbl[0] = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h0};
    tbl[1] = '{1'b0, 1'b1, 64'h4,  1'b1, 64'h0};
    tbl[2] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0};
    tbl[5] = '{1'b0, 1'b1, 64'h8,  1'b1, 64'h4};
    tbl[6] = '{1'b0, 1'b1, 64'hC,  1'b1, 64'h8};
    tbl[7] = '{1'b0, 1'b1, 64'h10, 1'b1, 64'hC};

    // reset state
    #3;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_pc", pc_if, 64'h0);
    chk("rst_npc", npc_if, 64'h0);
    chk("rst_inst", 64'(inst_if), 64'h0);
    chk("rst_valid", 64'(valid_if), 64'd0);
    chk("rst_exc", 64'(except_happen_if), 64'd0);
    chk("rst_cause", 64'(ecause_if), 64'd0);
    chk("rst_busy", 64'(if_busy), 64'd0);

    // streaming start-up and 3-cycle stall into the skid buffer
    do_reset();
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      stall = tbl[i].stall;
      tick();
      chk($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_valid", i), 64'(valid_if), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_pc", i), pc_if, tbl[i].exp_pc);
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_inst", i), 64'(inst_if), 64'(memf(tbl[i].exp_pc)));
        chk($sformatf("tbl%0d_npc", i), npc_if, tbl[i].exp_pc + 64'd4);
      end
    end

    // random stall, 1-cycle latency: in-order stream through slot and buffer
    do_reset();
    lat = 1;
    for (int i = 0; i < 20; i++) push(64'(i) * 64'd4, memf(64'(i) * 64'd4), 1'b0, 4'd0);
    for (int n = 0; n < 600 && sb_q.size() != 0; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall = 1'b0;
    wait_sb("stream_done", 1);

    // flush with a 2-cycle request pending: drain, discard stale word, restart at 0x80
    do_reset();
    lat = 2;
    tick();
    flush = 1'b1; redirect_pc = 64'h80;
    push(64'h80, memf(64'h80), 1'b0, 4'd0);
    push(64'h84, memf(64'h84), 1'b0, 4'd0);
    tick();
    flush = 1'b0;
    chk("drain_req", 64'(imem_req), 64'd1);
    chk("drain_addr", imem_addr, 64'h0);
    chk("drain_valid", 64'(valid_if), 64'd0);
    tick();
    chk("drain_hold_addr", imem_addr, 64'h0);
    tick();
    chk("redir_req", 64'(imem_req), 64'd1);
    chk("redir_addr", imem_addr, 64'h80);
    chk("redir_valid", 64'(valid_if), 64'd0);
    wait_sb("redir_stream", 50);

    // second flush while draining replaces the redirect target
    do_reset();
    lat = 2;
    tick();
    flush = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_pc = 64'h100;
    tick();
    flush = 1'b0;
    chk("drain2_addr", imem_addr, 64'h0);
    push(64'h100, memf(64'h100), 1'b0, 4'd0);
    tick();
    chk("drain2_redir", imem_addr, 64'h100);
    wait_sb("drain2_stream", 50);

    // misaligned redirect: exception with cause 0, no requests until the next flush
    do_reset();
    lat = 0;
    repeat (4) tick();
    flush = 1'b1; redirect_pc = 64'h82;
    push(64'h82, 32'h0, 1'b1, 4'd0);
    tick();
    flush = 1'b0;
    chk("mis_noreq", 64'(imem_req), 64'd0);
    tick();
    chk("mis_exc", 64'(except_happen_if), 64'd1);
    chk("mis_cause", 64'(ecause_if), 64'd0);
    chk("mis_pc", pc_if, 64'h82);
    chk("mis_valid", 64'(valid_if), 64'd0);
    wait_sb("mis_sb", 10);
    any_req = 1'b0;
    repeat (8) begin
      tick();
      any_req = any_req | imem_req;
    end
    chk("mis_exc_noreq", 64'(any_req), 64'd0);
    chk("mis_exc_empty", 64'(except_happen_if), 64'd0);
    chk("mis_exc_busy", 64'(if_busy), 64'd0);
    flush = 1'b1; redirect_pc = 64'h100;
    tick();
    flush = 1'b0;
    chk("mis_leave_req", 64'(imem_req), 64'd1);
    chk("mis_leave_addr", imem_addr, 64'h100);

    // access fault at 0x10: exception cause 1, fetching stops
    do_reset();
    lat = 0;
    fault_addr = 64'h10;
    for (int i = 0; i < 4; i++) push(64'(i) * 64'd4, memf(64'(i) * 64'd4), 1'b0, 4'd0);
    push(64'h10, 32'h0, 1'b1, 4'd1);
    wait_sb("fault_sb", 50);
    any_req = 1'b0;
    repeat (8) begin
      tick();
      any_req = any_req | imem_req;
    end
    chk("fault_noreq", 64'(any_req), 64'd0);
    chk("fault_empty", 64'(except_happen_if), 64'd0);

    // asynchronous reset mid-request, late ready ignored, restart at RESET_PC
    do_reset();
    lat = 3;
    tick();
    tick();
    chk("arst_pre_req", 64'(imem_req), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_addr", imem_addr, 64'h0);
    chk("arst_valid", 64'(valid_if), 64'd0);
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    force_ready = 1'b0;
    lat = 0;
    chk("arst_first_req", 64'(imem_req), 64'd1);
    chk("arst_first_addr", imem_addr, 64'h0);
    chk("arst_late_valid", 64'(valid_if), 64'd0);
    tick();
    chk("arst_fetch_valid", 64'(valid_if), 64'd1);
    chk("arst_fetch_inst", 64'(inst_if), 64'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
